// File: rtl/pipe_pkg.sv
// Shared definitions for the 64-bit pipeline: opcodes, instruction field
// positions and the ID/EX control and register bundles.
package pipe_pkg;

  localparam int XLEN        = 64;
  localparam int IMM_FIELD_W = 17;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd9;
  localparam logic [5:0] OP_SW   = 6'd10;
  localparam logic [5:0] OP_BEQ  = 6'd11;
  localparam logic [5:0] OP_BNE  = 6'd12;
  localparam logic [5:0] OP_J    = 6'd13;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 23;
  localparam int RS_MSB  = 22;
  localparam int RS_LSB  = 20;
  localparam int RT_MSB  = 19;
  localparam int RT_LSB  = 17;

  typedef struct packed {
    logic wena;
    logic memrd;
    logic memwr;
    logic branch;
    logic use_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } id_state_e;

  typedef struct packed {
    logic             valid;
    logic [5:0]       op;
    logic [2:0]       rd;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  imm;
    logic [31:0]      pc;
    ctrl_t            ctrl;
  } idex_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control bundle, which source fields are read,
// and the opcode as it is forwarded (unknown opcodes collapse to NOP).
module id_decoder
  import pipe_pkg::*;
(
  input  logic [5:0] op,
  output logic [5:0] op_norm,
  output ctrl_t      ctrl,
  output logic       use_rs,
  output logic       use_rt
);

  always_comb begin
    op_norm = op;
    ctrl    = CTRL_NONE;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        ctrl.wena = 1'b1;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      OP_ADDI: begin
        ctrl.wena    = 1'b1;
        ctrl.use_imm = 1'b1;
        use_rs       = 1'b1;
      end
      OP_LW: begin
        ctrl.wena    = 1'b1;
        ctrl.memrd   = 1'b1;
        ctrl.use_imm = 1'b1;
        use_rs       = 1'b1;
      end
      // rt carries the store data, so it is a real source for hazards
      OP_SW: begin
        ctrl.memwr   = 1'b1;
        ctrl.use_imm = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      OP_J: begin
        ctrl.branch = 1'b1;
      end
      default: op_norm = OP_NOP;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file addressing, ID/EX register, load-use
// stall FSM and bubble counter. Hazard logic is built only with LOAD_USE_STALL_EN.
module id_stage
  import pipe_pkg::*;
#(
  parameter int IMM_W = IMM_FIELD_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        ex_hold,
  output logic [2:0]  r0addr,
  output logic [2:0]  r1addr,
  input  logic [63:0] r0data,
  input  logic [63:0] r1data,
  output logic        stall,
  output logic        out_valid,
  output logic [5:0]  out_op,
  output logic [2:0]  out_rd,
  output logic [2:0]  out_rs,
  output logic [2:0]  out_rt,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [63:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_wena,
  output logic        out_memrd,
  output logic        out_memwr,
  output logic        out_branch,
  output logic        out_use_imm,
  output logic [31:0] stall_count,
  output logic        dbg_state
);

  // Handshake: IF presents in_valid/in_instr; while stall=1 IF must hold the
  // same instruction and PC for the next edge. out_valid marks a live ID/EX slot.

  logic [5:0] op_norm;
  ctrl_t      dec_ctrl;
  logic       use_rs;
  logic       use_rt;

  idex_t      idex_q, idex_d;
  idex_t      issue, bubble;
  id_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic       hazard;

  id_decoder u_dec (
    .op      (in_instr[OP_MSB:OP_LSB]),
    .op_norm (op_norm),
    .ctrl    (dec_ctrl),
    .use_rs  (use_rs),
    .use_rt  (use_rt)
  );

  assign r0addr = in_instr[RS_MSB:RS_LSB];
  assign r1addr = in_instr[RT_MSB:RT_LSB];

  always_comb begin
    issue       = '0;
    issue.valid = 1'b1;
    issue.op    = op_norm;
    issue.rd    = in_instr[RD_MSB:RD_LSB];
    issue.rs    = in_instr[RS_MSB:RS_LSB];
    issue.rt    = in_instr[RT_MSB:RT_LSB];
    issue.a     = r0data;
    issue.b     = r1data;
    issue.imm   = {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    issue.pc    = in_pc;
    issue.ctrl  = dec_ctrl;
    bubble       = issue;
    bubble.valid = 1'b0;
    bubble.ctrl  = CTRL_NONE;
  end

`ifdef LOAD_USE_STALL_EN
  // Only a load sitting in ID/EX can create a hazard; a bubble never can.
  always_comb begin
    hazard = in_valid && idex_q.valid && idex_q.ctrl.memrd && (state_q == ST_RUN) &&
             ((use_rs && (idex_q.rd == issue.rs)) || (use_rt && (idex_q.rd == issue.rt)));
  end
`else
  logic unused_srcs;
  assign unused_srcs = use_rs ^ use_rt;
  assign hazard      = 1'b0;
`endif

  always_comb begin
    idex_d  = idex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush) begin
      idex_d  = bubble;
      state_d = ST_RUN;
    end else if (ex_hold) begin
      stall = 1'b1;
    end else if (hazard) begin
      stall   = 1'b1;
      idex_d  = bubble;
      state_d = ST_STALL;
      cnt_d   = cnt_q + 32'd1;
    end else begin
      idex_d  = in_valid ? issue : bubble;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = idex_q.valid;
  assign out_op      = idex_q.op;
  assign out_rd      = idex_q.rd;
  assign out_rs      = idex_q.rs;
  assign out_rt      = idex_q.rt;
  assign out_a       = idex_q.a;
  assign out_b       = idex_q.b;
  assign out_imm     = idex_q.imm;
  assign out_pc      = idex_q.pc;
  assign out_wena    = idex_q.ctrl.wena;
  assign out_memrd   = idex_q.ctrl.memrd;
  assign out_memwr   = idex_q.ctrl.memwr;
  assign out_branch  = idex_q.ctrl.branch;
  assign out_use_imm = idex_q.ctrl.use_imm;
  assign stall_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed instruction sequences, a reference model of the
// ID/EX slot checked every cycle, and literal expectations for key scenarios.
module tb_id_stage;

`ifdef LOAD_USE_STALL_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        ex_hold = 1'b0;
  logic [2:0]  r0addr, r1addr;
  logic [63:0] r0data, r1data;
  logic        stall, out_valid;
  logic [5:0]  out_op;
  logic [2:0]  out_rd, out_rs, out_rt;
  logic [63:0] out_a, out_b, out_imm;
  logic [31:0] out_pc;
  logic        out_wena, out_memrd, out_memwr, out_branch, out_use_imm;
  logic [31:0] stall_count;
  logic        dbg_state;

  logic [63:0] rf [8];
  assign r0data = rf[r0addr];
  assign r1data = rf[r1addr];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_hold(ex_hold), .r0addr(r0addr), .r1addr(r1addr),
    .r0data(r0data), .r1data(r1data), .stall(stall), .out_valid(out_valid),
    .out_op(out_op), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc),
    .out_wena(out_wena), .out_memrd(out_memrd), .out_memwr(out_memwr),
    .out_branch(out_branch), .out_use_imm(out_use_imm),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Control as {wena, memrd, memwr, branch, use_imm}, taken from the opcode table.
  function automatic logic [4:0] spec_ctl(input logic [5:0] op);
    if (op >= 6'd1 && op <= 6'd7) return 5'b10000;
    if (op == 6'd8)  return 5'b10001;
    if (op == 6'd9)  return 5'b11001;
    if (op == 6'd10) return 5'b00101;
    if (op >= 6'd11 && op <= 6'd13) return 5'b00010;
    return 5'b00000;
  endfunction

  function automatic bit uses_rs(input logic [5:0] op);
    return op >= 6'd1 && op <= 6'd12;
  endfunction

  function automatic bit uses_rt(input logic [5:0] op);
    return (op >= 6'd1 && op <= 6'd7) || op == 6'd10 || op == 6'd11 || op == 6'd12;
  endfunction

  logic        m_valid = 1'b0;
  logic [5:0]  m_op = '0;
  logic [2:0]  m_rd = '0, m_rs = '0, m_rt = '0;
  logic [63:0] m_a = '0, m_b = '0, m_imm = '0;
  logic [31:0] m_pc = '0;
  logic [4:0]  m_ctl = '0;
  logic [31:0] m_cnt = '0;
  logic        m_st = 1'b0;

  function automatic bit model_hazard();
    logic [5:0] op;
    op = in_instr[31:26];
    if (!HAZ_EN) return 1'b0;
    return in_valid && m_valid && m_ctl[3] &&
           ((uses_rs(op) && m_rd == in_instr[22:20]) || (uses_rt(op) && m_rd == in_instr[19:17]));
  endfunction

  function automatic bit exp_stall();
    if (flush) return 1'b0;
    if (ex_hold) return 1'b1;
    return model_hazard();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_op = '0; m_rd = '0; m_rs = '0; m_rt = '0;
      m_a = '0; m_b = '0; m_imm = '0; m_pc = '0; m_ctl = '0; m_cnt = '0; m_st = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0; m_ctl = '0; m_st = 1'b0;
    end else if (ex_hold) begin
      m_st = m_st;
    end else if (model_hazard()) begin
      m_valid = 1'b0; m_ctl = '0; m_cnt = m_cnt + 32'd1; m_st = 1'b1;
    end else if (in_valid) begin
      m_valid = 1'b1;
      m_op    = (in_instr[31:26] <= 6'd13) ? in_instr[31:26] : 6'd0;
      m_rd    = in_instr[25:23];
      m_rs    = in_instr[22:20];
      m_rt    = in_instr[19:17];
      m_a     = rf[in_instr[22:20]];
      m_b     = rf[in_instr[19:17]];
      m_imm   = {47'd0, in_instr[16:0]} - (in_instr[16] ? 64'h2_0000 : 64'd0);
      m_pc    = in_pc;
      m_ctl   = spec_ctl(in_instr[31:26]);
      m_st    = 1'b0;
    end else begin
      m_valid = 1'b0; m_ctl = '0; m_st = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 64'(stall), 64'(exp_stall()));
      chk("r0addr", 64'(r0addr), 64'(in_instr[22:20]));
      chk("r1addr", 64'(r1addr), 64'(in_instr[19:17]));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_wena", 64'(out_wena), 64'(m_ctl[4]));
      chk("out_memrd", 64'(out_memrd), 64'(m_ctl[3]));
      chk("out_memwr", 64'(out_memwr), 64'(m_ctl[2]));
      chk("out_branch", 64'(out_branch), 64'(m_ctl[1]));
      chk("stall_count", 64'(stall_count), 64'(m_cnt));
      chk("fsm_state", 64'(dbg_state), 64'(m_st));
      if (m_valid) begin
        chk("out_use_imm", 64'(out_use_imm), 64'(m_ctl[0]));
        chk("out_op", 64'(out_op), 64'(m_op));
        chk("out_rd", 64'(out_rd), 64'(m_rd));
        chk("out_rs", 64'(out_rs), 64'(m_rs));
        chk("out_rt", 64'(out_rt), 64'(m_rt));
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_imm", out_imm, m_imm);
        chk("out_pc", 64'(out_pc), 64'(m_pc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [16:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic hd);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
    flush    = fl;
    ex_hold  = hd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 64'hC0DE_0000_0000_1000 + 64'(i) * 64'h1_0000_0001;
    rf[0] = 64'd0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_imm", out_imm, 64'd0);
    chk("rst stall_count", 64'(stall_count), 64'd0);
    chk("rst fsm", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    // ADDI r1,r0,-5
    set_in(1'b1, mk(6'd8, 3'd1, 3'd0, 3'd0, 17'h1FFFB), 32'h100, 1'b0, 1'b0);
    tick();
    chk("addi imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi wena", 64'(out_wena), 64'd1);
    chk("addi use_imm", 64'(out_use_imm), 64'd1);
    chk("addi valid", 64'(out_valid), 64'd1);
    chk("addi a", out_a, 64'd0);
    chk("addi pc", 64'(out_pc), 64'h100);

    // LW r2 then dependent ADD r3,r2,r4
    set_in(1'b1, mk(6'd9, 3'd2, 3'd1, 3'd0, 17'd4), 32'h104, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd1, 3'd3, 3'd2, 3'd4, 17'd0), 32'h108, 1'b0, 1'b0);
    #1;
    chk("lu stall", 64'(stall), 64'(HAZ_EN));
    tick();
    chk("lu bubble", 64'(out_valid), HAZ_EN ? 64'd0 : 64'd1);
    chk("lu count", 64'(stall_count), 64'(HAZ_EN));
    chk("lu fsm", 64'(dbg_state), 64'(HAZ_EN));
    rf[2] = 64'hDEAD_BEEF_0000_0002;
    #1;
    chk("lu stall2", 64'(stall), 64'd0);
    tick();
    chk("lu add a", out_a, 64'hDEAD_BEEF_0000_0002);
    chk("lu add op", 64'(out_op), 64'd1);
    chk("lu add valid", 64'(out_valid), 64'd1);
    chk("lu fsm run", 64'(dbg_state), 64'd0);

    // LW r2 then independent ADD r3,r5,r6
    set_in(1'b1, mk(6'd9, 3'd2, 3'd1, 3'd0, 17'd8), 32'h10C, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd1, 3'd3, 3'd5, 3'd6, 17'd0), 32'h110, 1'b0, 1'b0);
    #1;
    chk("nohaz stall", 64'(stall), 64'd0);
    tick();
    chk("nohaz count", 64'(stall_count), 64'(HAZ_EN));
    chk("nohaz rd", 64'(out_rd), 64'd3);

    // hazard and flush together
    set_in(1'b1, mk(6'd9, 3'd4, 3'd1, 3'd0, 17'd0), 32'h114, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd1, 3'd3, 3'd4, 3'd1, 17'd0), 32'h118, 1'b1, 1'b0);
    #1;
    chk("flush stall", 64'(stall), 64'd0);
    tick();
    chk("flush valid", 64'(out_valid), 64'd0);
    chk("flush wena", 64'(out_wena), 64'd0);
    chk("flush count", 64'(stall_count), 64'(HAZ_EN));
    chk("flush fsm", 64'(dbg_state), 64'd0);

    // ex_hold for three cycles over a valid ADD
    set_in(1'b1, mk(6'd1, 3'd1, 3'd2, 3'd3, 17'd0), 32'h200, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd2, 3'd5, 3'd6, 3'd7, 17'd0), 32'h204, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold stall", 64'(stall), 64'd1);
      tick();
      chk("hold op", 64'(out_op), 64'd1);
      chk("hold pc", 64'(out_pc), 64'h200);
    end
    set_in(1'b1, mk(6'd2, 3'd5, 3'd6, 3'd7, 17'd0), 32'h204, 1'b0, 1'b0);
    tick();
    chk("release op", 64'(out_op), 64'd2);
    chk("release pc", 64'(out_pc), 64'h204);

    // reset pulsed while stalled (LW r5 then SW using r5 as store data)
    set_in(1'b1, mk(6'd9, 3'd5, 3'd1, 3'd0, 17'd0), 32'h300, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd10, 3'd0, 3'd1, 3'd5, 17'd12), 32'h304, 1'b0, 1'b0);
    #1;
    chk("sw stall", 64'(stall), 64'(HAZ_EN));
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(out_valid), 64'd0);
    chk("arst count", 64'(stall_count), 64'd0);
    chk("arst fsm", 64'(dbg_state), 64'd0);
    chk("arst pc", 64'(out_pc), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post rst fsm", 64'(dbg_state), 64'd0);
    chk("post rst memwr", 64'(out_memwr), 64'd1);
    chk("post rst valid", 64'(out_valid), 64'd1);

    // unknown opcode decodes as NOP
    set_in(1'b1, mk(6'h3F, 3'd7, 3'd1, 3'd2, 17'h55), 32'h400, 1'b0, 1'b0);
    tick();
    chk("illegal op", 64'(out_op), 64'd0);
    chk("illegal wena", 64'(out_wena), 64'd0);
    chk("illegal valid", 64'(out_valid), 64'd1);

    // branch hazard on rt, and J that never reads sources
    set_in(1'b1, mk(6'd9, 3'd6, 3'd1, 3'd0, 17'd0), 32'h500, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd11, 3'd0, 3'd1, 3'd6, 17'h1FFF0), 32'h504, 1'b0, 1'b0);
    #1;
    chk("beq stall", 64'(stall), 64'(HAZ_EN));
    tick();
    tick();
    chk("beq branch", 64'(out_branch), 64'd1);
    set_in(1'b1, mk(6'd9, 3'd7, 3'd1, 3'd0, 17'd0), 32'h508, 1'b0, 1'b0);
    tick();
    set_in(1'b1, mk(6'd13, 3'd0, 3'd7, 3'd7, 17'h100), 32'h50C, 1'b0, 1'b0);
    #1;
    chk("j stall", 64'(stall), 64'd0);
    tick();

    // sweep all opcodes plus a few unknown ones
    for (int op = 0; op < 16; op++) begin
      set_in(1'b1, mk(6'(op), 3'(op % 8), 3'((op + 1) % 8), 3'((op + 2) % 8), 17'(op * 32'h1111)),
             32'h600 + 32'(op * 4), 1'b0, 1'b0);
      tick();
    end

    // idle IF/ID loads a bubble
    set_in(1'b0, mk(6'd1, 3'd1, 3'd2, 3'd3, 17'd0), 32'h700, 1'b0, 1'b0);
    tick();
    chk("idle valid", 64'(out_valid), 64'd0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
